// File: rtl/card_lock_if.sv
// Reader-side and checker-side signals of the shared card-lock scheduler.
interface card_lock_if #(
    parameter int NUM_DOORS = 4
);
    localparam int DW = $clog2(NUM_DOORS);

    logic [NUM_DOORS-1:0]    rd_req;
    logic [16*NUM_DOORS-1:0] rd_code;
    logic [2*NUM_DOORS-1:0]  rd_type;
    logic [NUM_DOORS-1:0]    rd_ack;
    logic                    chk_strobe;
    logic [15:0]             chk_code;
    logic [1:0]              chk_type;
    logic [DW-1:0]           chk_door;
    logic                    chk_result;
    logic [NUM_DOORS-1:0]    door_unlock;
    logic [NUM_DOORS-1:0]    door_deny;
    logic                    busy;

    modport master (
        output rd_req, rd_code, rd_type, chk_result,
        input  rd_ack, chk_strobe, chk_code, chk_type, chk_door,
        input  door_unlock, door_deny, busy
    );

    modport slave (
        input  rd_req, rd_code, rd_type, chk_result,
        output rd_ack, chk_strobe, chk_code, chk_type, chk_door,
        output door_unlock, door_deny, busy
    );
endinterface

// File: rtl/card_lock_scheduler.sv
// Round-robin scheduler sharing one card-code checker between several readers,
// with an independent relock timer per door.
module card_lock_scheduler #(
    parameter int NUM_DOORS     = 4,
    parameter int CHECK_LATENCY = 2,
    parameter int UNLOCK_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    card_lock_if.slave bus
);
    localparam int DW = $clog2(NUM_DOORS);
    localparam int TW = $clog2(UNLOCK_CYCLES + 1);
    localparam int CW = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;

    // state    | meaning
    // S_IDLE   | arbitrate among pending readers
    // S_STROBE | strobe to checker and ack to granted reader
    // S_WAIT   | wait for checker verdict, then apply it
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]           r_state;
    logic [DW-1:0]        r_rr_ptr;
    logic [DW-1:0]        r_door;
    logic [15:0]          r_code;
    logic [1:0]           r_type;
    logic [CW-1:0]        r_cnt;
    logic                 r_strobe;
    logic [NUM_DOORS-1:0] r_ack;
    logic [NUM_DOORS-1:0] r_deny;
    logic [NUM_DOORS-1:0] r_unlock;
    logic [TW-1:0]        r_timer     [NUM_DOORS];

    logic                 w_found;
    logic [DW-1:0]        w_grant;
    logic                 w_verdict;
    logic                 w_accept;
    logic [TW-1:0]        w_timer_nxt [NUM_DOORS];

    // First requester at or after the round-robin pointer, circularly.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_DOORS; k++) begin
            j = (int'(r_rr_ptr) + k) % NUM_DOORS;
            if (!w_found && bus.rd_req[j]) begin
                w_found = 1'b1;
                w_grant = DW'(j);
            end
        end
    end

    assign w_verdict = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_accept  = w_verdict && bus.chk_result;

    // Reload takes priority over the running decrement so an extension never dips.
    always_comb begin
        for (int i = 0; i < NUM_DOORS; i++) begin
            w_timer_nxt[i] = r_timer[i];
            if (r_timer[i] != '0)
                w_timer_nxt[i] = r_timer[i] - 1'b1;
            if (w_accept && (r_door == DW'(i)))
                w_timer_nxt[i] = TW'(UNLOCK_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_door   <= '0;
            r_code   <= '0;
            r_type   <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_ack    <= '0;
            r_deny   <= '0;
            r_unlock <= '0;
            for (int i = 0; i < NUM_DOORS; i++)
                r_timer[i] <= '0;
        end else begin
            r_strobe <= 1'b0;
            r_ack    <= '0;
            r_deny   <= '0;
            for (int i = 0; i < NUM_DOORS; i++) begin
                r_timer[i]  <= w_timer_nxt[i];
                r_unlock[i] <= (w_timer_nxt[i] != '0);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_door         <= w_grant;
                        r_code         <= bus.rd_code[16*w_grant +: 16];
                        r_type         <= bus.rd_type[2*w_grant +: 2];
                        r_rr_ptr       <= (w_grant == DW'(NUM_DOORS - 1)) ? '0 : w_grant + 1'b1;
                        r_strobe       <= 1'b1;
                        r_ack[w_grant] <= 1'b1;
                        r_state        <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_cnt   <= CW'(CHECK_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!bus.chk_result)
                            r_deny[r_door] <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_ack      = r_ack;
    assign bus.chk_strobe  = r_strobe;
    assign bus.chk_code    = r_code;
    assign bus.chk_type    = r_type;
    assign bus.chk_door    = r_door;
    assign bus.door_unlock = r_unlock;
    assign bus.door_deny   = r_deny;
    assign bus.busy        = (r_state != S_IDLE);
endmodule
